btb_table: RTL
==============

// Module: btb_table
// PURPOSE
//  Branch target buffer storage: the writer/holder end of the PC controller's predictor interface.
//  Holds NUM_ENTRIES {tag, bias} entries and presents all of them combinationally as predictor[].
//  Absorbs update writes raised on ID-stage branch mispredictions.
//  Provides a multi-cycle flush (fence.i / context switch) and occupancy/update statistics.
// PARAMETERS
//  NUM_ENTRIES  8   table depth; power of two
//  IDX_W        3   log2(NUM_ENTRIES); width of update_adr
//  TAG_W        21  entry tag = {1'b0, pc[21:2]}; MSB=1 marks an invalid entry
//  BIAS_W       32  predicted PC increment (4 = not taken)
// PORTS
//  clk               in   1                  rising-edge clock
//  rst               in   1                  synchronous, active-high reset
//  update_predictor  in   1                  write request, one entry, single cycle
//  update_adr        in   IDX_W              victim index chosen by the predictor processor
//  update_val        in   TAG_W+BIAS_W       new entry {tag, bias}
//  flush_req         in   1                  single-cycle pulse: invalidate whole table
//  flush_busy        out  1                  high while flush sequence is in progress
//  predictor         out  [NUM_ENTRIES][53]  current table contents (masked while flushing)
//  occupancy         out  IDX_W+1            number of valid entries, 0..NUM_ENTRIES
//  update_cnt        out  32                 accepted writes, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset: every entry = INVALID_ENTRY = {1'b1, 20'b0, 32'd4}; occupancy=0; update_cnt=0;
//   flush_busy=0; FSM=IDLE. Reset mid-flush aborts to IDLE with the table fully invalid.
//  Entry is valid iff tag[TAG_W-1]==0; invalid tags never match a lookup ({1'b0, pc[21:2]}).
//  FSM IDLE:
//   - flush_req=1 -> FLUSH, idx=0. flush_req has priority: a same-cycle update is dropped.
//   - else update_predictor=1 and update_val[52]==0 -> write accepted:
//     target = lowest valid entry whose tag == update_val tag (dedup), else update_adr.
//     Entry written at the clock edge; visible on predictor[] the next cycle (1-cycle latency).
//     occupancy +1 only if target was invalid; update_cnt +1 (saturating).
//   - update_val[52]==1 (malformed) -> ignored; no state or counter change.
//  FSM FLUSH: each cycle entry[idx] <= INVALID_ENTRY, idx++. After idx==NUM_ENTRIES-1
//   is cleared -> IDLE, occupancy=0. Sequence lasts exactly NUM_ENTRIES cycles.
//   flush_busy is registered: 1 in every FLUSH cycle, 0 in the first IDLE cycle.
//   While in FLUSH: all predictor[] outputs forced to INVALID_ENTRY (no stale prediction);
//   update_predictor ignored and not counted; flush_req ignored (no restart).
//  Table has one write port: one entry written per cycle at most (LUTRAM-mappable).
//  predictor[] is driven combinationally from the registers plus the flush mask; there is
//   no write-through bypass.
// STRUCTURE
//  btb_pkg: NUM_ENTRIES, IDX_W, TAG_W, BIAS_W, ENTRY_W=53, packed struct btb_entry_t
//   {tag, bias}, INVALID_ENTRY, enum btb_state_e {BTB_IDLE, BTB_FLUSH}.
//  Sub-module btb_match_enc: combinational tag compare across all entries; outputs hit
//   flag and lowest hit index. Used for dedup; reusable by the predictor processor.
// TESTING
//  1 Reset, then read all entries -> each = {1'b1, 20'b0, 32'd4}; occupancy=0; update_cnt=0.
//  2 Write adr=3, val={1'b0, 20'h00010, 32'h40} -> next cycle predictor[3] holds the value;
//    occupancy=1; update_cnt=1.
//  3 Repeat tag 20'h00010 with bias 32'd4 and adr=5 -> entry 3 overwritten (bias 4);
//    entry 5 still invalid; occupancy=1; update_cnt=2.
//  4 Fill all 8 entries, pulse flush_req -> flush_busy high for exactly 8 cycles;
//    predictor[] reads all-invalid from the first busy cycle; occupancy=0 after.
//  5 flush_req and update_predictor in the same cycle -> no write, update_cnt unchanged.
//    An update at flush cycle 4 is dropped.
//  6 Assert rst at flush cycle 3 -> FSM in IDLE and flush_busy=0 next cycle; table invalid.
//    Write update_val[52]=1 -> ignored.

Source files
------------

// File: rtl/btb_pkg.sv
// ============================================================================
// btb_pkg : shared types and constants for the branch target buffer table
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package btb_pkg;

   localparam int NUM_ENTRIES = 8;
   localparam int IDX_W       = 3;
   localparam int TAG_W       = 21;
   localparam int BIAS_W      = 32;
   localparam int ENTRY_W     = TAG_W + BIAS_W;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [BIAS_W-1:0] bias;
   } btb_entry_t;

   // Tag MSB set marks an empty slot; bias 4 means "fall through" if ever used.
   localparam btb_entry_t INVALID_ENTRY = '{tag: {1'b1, {(TAG_W-1){1'b0}}}, bias: 32'd4};

   typedef enum logic [0:0] {
      BTB_IDLE  = 1'b0,
      BTB_FLUSH = 1'b1
   } btb_state_e;

   function automatic logic entry_valid(input btb_entry_t e);
      return ~e.tag[TAG_W-1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/btb_match_enc.sv
// ============================================================================
// btb_match_enc : parallel tag compare over all entries, lowest-index hit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module btb_match_enc
   import btb_pkg::*;
(
   input  btb_entry_t [NUM_ENTRIES-1:0] entries_i,
   input  logic [TAG_W-1:0]             tag_i,
   output logic                         hit_o,
   output logic [IDX_W-1:0]             hit_idx_o
);

   logic [NUM_ENTRIES-1:0] w_match;

   generate
      for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cmp
         assign w_match[i] = entry_valid(entries_i[i]) && (entries_i[i].tag == tag_i);
      end
   endgenerate

   // Scan downwards so the lowest matching index wins.
   always_comb begin
      hit_o     = |w_match;
      hit_idx_o = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (w_match[i]) hit_idx_o = IDX_W'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/btb_table.sv
// ============================================================================
// btb_table : BTB entry storage with dedup-on-write, multi-cycle flush, stats
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module btb_table
   import btb_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          update_predictor_i,
   input  logic [IDX_W-1:0]              update_adr_i,
   input  logic [ENTRY_W-1:0]            update_val_i,
   input  logic                          flush_req_i,
   output logic                          flush_busy_o,
   output btb_entry_t [NUM_ENTRIES-1:0]  predictor_o,
   output logic [IDX_W:0]                occupancy_o,
   output logic [31:0]                   update_cnt_o
);

   btb_entry_t [NUM_ENTRIES-1:0] table_q;
   btb_state_e                   state_q;
   logic [IDX_W-1:0]             idx_q;
   logic [IDX_W:0]               occ_q;
   logic [31:0]                  cnt_q;
   logic                         busy_q;

   btb_entry_t       w_new;
   logic             w_hit;
   logic [IDX_W-1:0] w_hit_idx;
   logic [IDX_W-1:0] w_tgt;
   logic             w_accept;
   logic             w_tgt_empty;
   logic             w_we;
   logic [IDX_W-1:0] w_widx;
   btb_entry_t       w_wdata;

   assign w_new = btb_entry_t'(update_val_i);

   btb_match_enc u_match (
      .entries_i (table_q),
      .tag_i     (w_new.tag),
      .hit_o     (w_hit),
      .hit_idx_o (w_hit_idx)
   );

   assign w_accept    = (state_q == BTB_IDLE) && !flush_req_i && update_predictor_i
                        && entry_valid(w_new);
   assign w_tgt       = w_hit ? w_hit_idx : update_adr_i;
   assign w_tgt_empty = !entry_valid(table_q[w_tgt]);

   // Single write port shared between update writes and flush clears.
   always_comb begin
      w_we    = 1'b0;
      w_widx  = w_tgt;
      w_wdata = w_new;
      if (state_q == BTB_FLUSH) begin
         w_we    = 1'b1;
         w_widx  = idx_q;
         w_wdata = INVALID_ENTRY;
      end else if (w_accept) begin
         w_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= INVALID_ENTRY;
         state_q <= BTB_IDLE;
         idx_q   <= '0;
         occ_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         if (w_we) table_q[w_widx] <= w_wdata;
         case (state_q)
            BTB_IDLE: begin
               if (flush_req_i) begin
                  state_q <= BTB_FLUSH;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (w_accept) begin
                  if (w_tgt_empty) occ_q <= occ_q + 1'b1;
                  if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
               end
            end
            BTB_FLUSH: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                  state_q <= BTB_IDLE;
                  busy_q  <= 1'b0;
                  occ_q   <= '0;
               end
            end
            default: state_q <= BTB_IDLE;
         endcase
      end
   end

   generate
      for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_out
         assign predictor_o[i] = (state_q == BTB_FLUSH) ? INVALID_ENTRY : table_q[i];
      end
   endgenerate

   assign flush_busy_o = busy_q;
   assign occupancy_o  = occ_q;
   assign update_cnt_o = cnt_q;

endmodule

`default_nettype wire
